imr_dac_121s101_x2_core: RTL and testbench

IMR_DAC_121S101_X2_CORE -- requirements
Module: imr_dac_121s101_x2_core

---
 rtl/imr_dac_121s101_x2_core.sv | 195 +++++++++++++++++++
 tb/tb_imr_dac_121s101_x2_core.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imr_dac_121s101_x2_core.sv
// Dual DAC121S101 serial front end.
// Two 12-bit codes go out as 16-bit frames on a shared SCLK/SYNC_n pair,
// with optional continuous bursts and an interrupt on completion.
`timescale 1ns/1ps
module imr_dac_121s101_x2_core #(
    parameter int unsigned FRAME_CLKS     = 16,
    parameter int unsigned QUIET_SYS_CLKS = 4,
    parameter logic [3:0]  CORE_REV       = 4'd1
) (
    input  logic        SysClk,
    input  logic        RST_n,
    input  logic [31:0] Ctrl_Register,
    input  logic [31:0] IRQ_Register,
    input  logic [31:0] DAC_Data_A_Register,
    input  logic [31:0] DAC_Data_B_Register,
    output logic [31:0] Status_Register,
    output logic        SCLK,
    output logic        SYNC_n,
    output logic        MOSI_A,
    output logic        MOSI_B,
    output logic        IP_IRQ
);

    localparam int unsigned BIT_W   = $clog2(FRAME_CLKS + 1);
    localparam int unsigned QUIET_W = $clog2(QUIET_SYS_CLKS + 1);
    localparam int unsigned DIV_W   = 4;
    localparam int unsigned FC_W    = 12;
    localparam int unsigned SH_W    = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_QUIET = 3'd4,
        S_NEXT  = 3'd5
    } state_t;

    state_t             state;
    logic               start_q;
    logic               sclk_fell;
    logic               busy;
    logic               done;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [QUIET_W-1:0] quiet_cnt;
    logic [FC_W-1:0]    frame_cnt;
    logic [SH_W-1:0]    sh_a;
    logic [SH_W-1:0]    sh_b;

    // Control field decode
    logic             en;
    logic             start;
    logic             cont;
    logic [3:0]       clkdiv_n;
    logic [1:0]       pd;
    logic [FC_W-1:0]  update_cnt;
    logic             irq_en;
    logic             irq_clr;
    logic [DIV_W-1:0] neff;
    logic [FC_W-1:0]  last_frame;
    logic             trig;
    logic             div_wrap;
    logic             unused_bits;

    assign en         = Ctrl_Register[0];
    assign start      = Ctrl_Register[1];
    assign cont       = Ctrl_Register[2];
    assign clkdiv_n   = Ctrl_Register[7:4];
    assign pd         = Ctrl_Register[9:8];
    assign update_cnt = Ctrl_Register[23:12];
    assign irq_en     = IRQ_Register[0];
    assign irq_clr    = IRQ_Register[1];

    // Divider is clamped so SCLK never exceeds SysClk/6
    assign neff       = (clkdiv_n < 4'd3) ? 4'd3 : clkdiv_n;
    // Index of the last frame in a burst; a zero count still sends one frame
    assign last_frame = (update_cnt == 12'd0) ? 12'd0 : update_cnt - 12'd1;
    assign trig       = start & ~start_q & en;
    assign div_wrap   = (div_cnt == neff - 4'd1);

    assign unused_bits = ^{Ctrl_Register[31:24], Ctrl_Register[11:10], Ctrl_Register[3],
                           IRQ_Register[31:2], DAC_Data_A_Register[31:12],
                           DAC_Data_B_Register[31:12]};

    assign MOSI_A          = sh_a[SH_W-1];
    assign MOSI_B          = sh_b[SH_W-1];
    assign IP_IRQ          = irq_en & done;
    assign Status_Register = {CORE_REV, 8'h00, frame_cnt, 1'b0, state, 2'b00, done, busy};

    // Frame sequencer: start detect, SCLK divider, shifting, burst control
    always_ff @(posedge SysClk or negedge RST_n) begin
        if (!RST_n) begin
            state     <= S_IDLE;
            start_q   <= 1'b1;
            sclk_fell <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            quiet_cnt <= '0;
            frame_cnt <= '0;
            sh_a      <= '0;
            sh_b      <= '0;
            SCLK      <= 1'b0;
            SYNC_n    <= 1'b1;
        end else begin
            start_q <= start;
            case (state)
                S_IDLE: begin
                    SCLK    <= 1'b0;
                    SYNC_n  <= 1'b1;
                    div_cnt <= '0;
                    sh_a    <= '0;
                    sh_b    <= '0;
                    if (trig) begin
                        state     <= S_LOAD;
                        frame_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    SCLK    <= 1'b0;
                    div_cnt <= '0;
                    // A pending interrupt holds off the next frame
                    if (!IP_IRQ) begin
                        sh_a      <= {2'b00, pd, DAC_Data_A_Register[11:0]};
                        sh_b      <= {2'b00, pd, DAC_Data_B_Register[11:0]};
                        SYNC_n    <= 1'b0;
                        bit_cnt   <= '0;
                        sclk_fell <= 1'b0;
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Shift one cycle after SCLK falls so data holds past the DAC sample edge
                    if (sclk_fell) begin
                        sh_a      <= {sh_a[SH_W-2:0], 1'b0};
                        sh_b      <= {sh_b[SH_W-2:0], 1'b0};
                        bit_cnt   <= bit_cnt + BIT_W'(1);
                        sclk_fell <= 1'b0;
                    end
                    if (div_wrap) begin
                        div_cnt   <= '0;
                        SCLK      <= ~SCLK;
                        sclk_fell <= SCLK;
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                    if (sclk_fell && bit_cnt == BIT_W'(FRAME_CLKS - 1)) begin
                        state   <= S_HOLD;
                        SCLK    <= 1'b0;
                        div_cnt <= '0;
                    end
                end
                S_HOLD: begin
                    SYNC_n    <= 1'b1;
                    quiet_cnt <= '0;
                    state     <= S_QUIET;
                end
                S_QUIET: begin
                    if (quiet_cnt == QUIET_W'(QUIET_SYS_CLKS - 1)) begin
                        if (cont && en && frame_cnt < last_frame) begin
                            frame_cnt <= frame_cnt + 12'd1;
                            state     <= S_NEXT;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            sh_a  <= '0;
                            sh_b  <= '0;
                            state <= S_IDLE;
                        end
                    end else begin
                        quiet_cnt <= quiet_cnt + QUIET_W'(1);
                    end
                end
                S_NEXT: begin
                    bit_cnt <= '0;
                    state   <= S_LOAD;
                end
                default: begin
                    SCLK   <= 1'b0;
                    SYNC_n <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
            // Clear has priority over a same-cycle completion
            if (irq_clr) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imr_dac_121s101_x2_core.sv
// Bench for imr_dac_121s101_x2_core: a waveform monitor rebuilds each SPI
// frame and a spec-level model predicts frame words, timing and status.
`timescale 1ns/1ps
module tb_imr_dac_121s101_x2_core;

    localparam int unsigned QUIET = 4;
    localparam logic [3:0]  REV   = 4'd1;

    logic        SysClk = 1'b0;
    logic        RST_n;
    logic [31:0] Ctrl_Register;
    logic [31:0] IRQ_Register;
    logic [31:0] DAC_A;
    logic [31:0] DAC_B;
    logic [31:0] Status_Register;
    logic        SCLK, SYNC_n, MOSI_A, MOSI_B, IP_IRQ;

    logic        en, start, cont, irq_en, irq_clr;
    logic [3:0]  div_n;
    logic [1:0]  pd;
    logic [11:0] upd;
    logic [7:0]  junk;

    assign Ctrl_Register = {junk, upd, 2'b00, pd, div_n, 1'b0, cont, start, en};
    assign IRQ_Register  = {30'h0, irq_clr, irq_en};

    imr_dac_121s101_x2_core #(
        .FRAME_CLKS(16), .QUIET_SYS_CLKS(QUIET), .CORE_REV(REV)
    ) dut (
        .SysClk(SysClk), .RST_n(RST_n),
        .Ctrl_Register(Ctrl_Register), .IRQ_Register(IRQ_Register),
        .DAC_Data_A_Register(DAC_A), .DAC_Data_B_Register(DAC_B),
        .Status_Register(Status_Register),
        .SCLK(SCLK), .SYNC_n(SYNC_n), .MOSI_A(MOSI_A), .MOSI_B(MOSI_B), .IP_IRQ(IP_IRQ)
    );

    always #5 SysClk = ~SysClk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          nb;
        int          low_len;
        int          hmin;
        int          hmax;
        int          gap;
    } frame_t;

    frame_t frames[$];
    frame_t cur;
    bit     in_frame = 1'b0;
    logic   prev_sclk = 1'b0;
    int     run = 0;
    int     high_len = 0;
    int     sclk_idle_bad = 0;
    int     irq_busy_bad = 0;
    int     checks = 0;
    int     failures = 0;

    // Rebuild frames from the pins: bits captured on SCLK falling edges
    initial begin : monitor
        forever begin
            @(negedge SysClk);
            if (IP_IRQ && Status_Register[0]) irq_busy_bad++;
            if (!SYNC_n) begin
                if (!in_frame) begin
                    in_frame    = 1'b1;
                    cur.a       = '0;
                    cur.b       = '0;
                    cur.nb      = 0;
                    cur.low_len = 0;
                    cur.hmin    = 100000;
                    cur.hmax    = 0;
                    cur.gap     = high_len;
                    run         = 0;
                end
                cur.low_len++;
                if (SCLK) begin
                    if (!prev_sclk) run = 0;
                    run++;
                end else if (prev_sclk) begin
                    cur.a = {cur.a[14:0], MOSI_A};
                    cur.b = {cur.b[14:0], MOSI_B};
                    cur.nb++;
                    if (run < cur.hmin) cur.hmin = run;
                    if (run > cur.hmax) cur.hmax = run;
                end
            end else begin
                if (in_frame) begin
                    frames.push_back(cur);
                    in_frame = 1'b0;
                    high_len = 0;
                end
                high_len++;
                if (SCLK) sclk_idle_bad++;
            end
            prev_sclk = SCLK;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input int fc, input bit dn, input bit bsy, input int st);
        return {REV, 8'h00, 12'(fc), 1'b0, 3'(st), 2'b00, dn, bsy};
    endfunction

    function automatic int neff_of(input int n);
        return (n < 3) ? 3 : n;
    endfunction

    task automatic kick();
        @(posedge SysClk); #1 start = 1'b1;
        @(posedge SysClk); #1 start = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge SysClk); #1 irq_clr = 1'b1;
        @(posedge SysClk); #1 irq_clr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        do begin
            @(negedge SysClk);
            k++;
        end while ((Status_Register[0] !== 1'b0 || Status_Register[6:4] !== 3'd0) && k < 20000);
        chk({tag, "_idle_in_time"}, 32'(k < 20000), 32'd1);
    endtask

    task automatic wait_falls(input string tag, input int n);
        int k = 0;
        do begin
            @(negedge SysClk);
            k++;
        end while (!(in_frame && cur.nb >= n) && k < 5000);
        chk({tag, "_falls_in_time"}, 32'(k < 5000), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                               input int n, input bit check_gap);
        frame_t f;
        int ne;
        ne = neff_of(n);
        chk({tag, "_frame_present"}, 32'(frames.size() > 0), 32'd1);
        if (frames.size() == 0) return;
        f = frames.pop_front();
        chk({tag, "_mosi_a"}, 32'(f.a), 32'(ea));
        chk({tag, "_mosi_b"}, 32'(f.b), 32'(eb));
        chk({tag, "_nbits"}, 32'(f.nb), 32'd16);
        chk({tag, "_half_min"}, 32'(f.hmin), 32'(ne));
        chk({tag, "_half_max"}, 32'(f.hmax), 32'(ne));
        chk({tag, "_sync_len_ok"},
            32'(f.low_len >= 32 * ne + 2 && f.low_len <= 32 * ne + 3), 32'd1);
        if (check_gap) chk({tag, "_gap_ok"}, 32'(f.gap >= int'(QUIET)), 32'd1);
    endtask

    // One complete start-to-idle transaction checked against the model
    task automatic run_case(input string tag, input bit c, input int u, input int n,
                            input logic [1:0] p, input logic [31:0] a, input logic [31:0] b);
        int nexp;
        cont  = c;
        upd   = 12'(u);
        div_n = 4'(n);
        pd    = p;
        DAC_A = a;
        DAC_B = b;
        junk  = 8'($urandom);
        kick();
        wait_idle(tag);
        nexp = c ? ((u == 0) ? 1 : u) : 1;
        chk({tag, "_frame_count"}, 32'(frames.size()), 32'(nexp));
        for (int i = 0; i < nexp; i++)
            check_frame(tag, {2'b00, p, a[11:0]}, {2'b00, p, b[11:0]}, n, i > 0);
        chk({tag, "_status"}, Status_Register, exp_status(nexp - 1, 1'b1, 1'b0, 0));
        frames.delete();
    endtask

    initial begin : stim
        logic [31:0] ra, rb;
        logic [1:0]  rp;
        RST_n = 1'b0; en = 1'b0; start = 1'b0; cont = 1'b0; div_n = 4'd0; pd = 2'd0;
        upd = 12'd0; junk = 8'd0; irq_en = 1'b0; irq_clr = 1'b0; DAC_A = '0; DAC_B = '0;

        // Reset state
        repeat (3) @(negedge SysClk);
        chk("rst_status", Status_Register, exp_status(0, 1'b0, 1'b0, 0));
        chk("rst_sclk", 32'(SCLK), 32'd0);
        chk("rst_sync", 32'(SYNC_n), 32'd1);
        chk("rst_mosi", 32'({MOSI_A, MOSI_B}), 32'd0);
        chk("rst_irq", 32'(IP_IRQ), 32'd0);
        @(posedge SysClk); #1 RST_n = 1'b1;
        repeat (2) @(negedge SysClk);
        en = 1'b1;

        // Single frame at 10 MHz SCLK
        run_case("single", 1'b0, 0, 5, 2'b00, 32'h0000_0ABC, 32'h0000_0123);
        pulse_clr();
        @(negedge SysClk);
        chk("clr_done", Status_Register, exp_status(0, 1'b0, 1'b0, 0));

        // Randomized single and burst transactions
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rp = 2'($urandom_range(0, 3));
            run_case($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 4)), int'($urandom_range(0, 7)), rp, ra, rb);
        end

        // Continuous burst of three with interrupt only at the end
        pulse_clr();
        irq_en = 1'b1;
        irq_busy_bad = 0;
        run_case("cont3", 1'b1, 3, 5, 2'b01, $urandom, $urandom);
        chk("cont3_irq_quiet_while_busy", 32'(irq_busy_bad), 32'd0);
        chk("cont3_irq_set", 32'(IP_IRQ), 32'd1);

        // Pending interrupt stalls the next frame in LOAD
        kick();
        repeat (20) @(negedge SysClk);
        chk("stall_state", 32'(Status_Register[6:4]), 32'd1);
        chk("stall_sync", 32'(SYNC_n), 32'd1);
        chk("stall_no_frame", 32'(frames.size() + int'(in_frame)), 32'd0);
        DAC_A = 32'h0000_0456; DAC_B = 32'h0000_0789; pd = 2'b00; div_n = 4'd5; cont = 1'b0;
        pulse_clr();
        wait_idle("stall");
        check_frame("stall", 16'h0456, 16'h0789, 5, 1'b0);
        chk("stall_irq_after", 32'(IP_IRQ), 32'd1);
        irq_en = 1'b0;
        frames.delete();

        // Divider clamp and power-down bits
        run_case("clamp0", 1'b0, 0, 0, 2'b11, $urandom, $urandom);
        run_case("clamp1", 1'b0, 0, 1, 2'b11, $urandom, $urandom);
        run_case("upd0", 1'b1, 0, 3, 2'b10, $urandom, $urandom);

        // EN dropped mid-frame: current frame finishes, burst ends
        cont = 1'b1; upd = 12'd3; div_n = 4'd4; pd = 2'b00;
        DAC_A = 32'h0000_0321; DAC_B = 32'h0000_0654;
        kick();
        wait_falls("endrop", 5);
        en = 1'b0;
        wait_idle("endrop");
        chk("endrop_frames", 32'(frames.size()), 32'd1);
        check_frame("endrop", 16'h0321, 16'h0654, 4, 1'b0);
        chk("endrop_status", Status_Register, exp_status(0, 1'b1, 1'b0, 0));
        frames.delete();
        en = 1'b1;

        // Data rewrite mid-shift lands in the next frame only
        ra = 32'($urandom_range(0, 32'hFFE));
        cont = 1'b1; upd = 12'd2; div_n = 4'd3; DAC_A = ra; DAC_B = 32'h0000_0AAA;
        kick();
        wait_falls("stab", 6);
        DAC_A = 32'h0000_0FFF;
        wait_idle("stab");
        chk("stab_frames", 32'(frames.size()), 32'd2);
        check_frame("stab_f0", {4'h0, ra[11:0]}, 16'h0AAA, 3, 1'b0);
        check_frame("stab_f1", 16'h0FFF, 16'h0AAA, 3, 1'b1);
        frames.delete();

        // Reset mid-frame aborts immediately; START held high must not restart
        cont = 1'b0; div_n = 4'd5; DAC_A = 32'h0000_0F0F; DAC_B = 32'h0000_00F0;
        kick();
        wait_falls("abort", 8);
        #2 RST_n = 1'b0;
        #1;
        chk("abort_sync", 32'(SYNC_n), 32'd1);
        chk("abort_sclk", 32'(SCLK), 32'd0);
        chk("abort_status", Status_Register, exp_status(0, 1'b0, 1'b0, 0));
        chk("abort_mosi", 32'({MOSI_A, MOSI_B}), 32'd0);
        start = 1'b1;
        repeat (3) @(negedge SysClk);
        @(posedge SysClk); #1 RST_n = 1'b1;
        repeat (100) @(negedge SysClk);
        chk("abort_stays_idle", Status_Register, exp_status(0, 1'b0, 1'b0, 0));
        chk("abort_partial_frames", 32'(frames.size()), 32'd1);
        if (frames.size() > 0) chk("abort_partial_bits", 32'(frames[0].nb), 32'd8);
        frames.delete();
        start = 1'b0;
        run_case("after_rst", 1'b0, 0, 6, 2'b01, $urandom, $urandom);

        chk("sclk_idle_low", 32'(sclk_idle_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
